return_stack: RTL
=================

Name: return_stack

Overview:
- Parametrised LIFO return-address stack for the basic CPU. It is the successor to the fixed 16x10 stack.
- Adds configurable width and depth, optional increment-on-push of the return address, and full/empty/count status.
- Adds sticky overflow/underflow error flags, a defined push+pop "replace" operation, and a selectable full-stack policy: reject, or overwrite the oldest entry (circular).
- Sits between the program counter and the next-PC mux. CALL drives push with din = PC. RET drives pop and uses dout as the next PC.

Parameters:
- WIDTH, 10, data/address width in bits.
- DEPTH, 16, number of entries (≥2, any integer; not required to be a power of two).
- INC_ON_PUSH, 1, when 1 the value stored is din+1 (mod 2^WIDTH); when 0 it is din.
- OVF_MODE, 0, push-when-full policy: 0 = reject the push; 1 = overwrite the oldest entry.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- push  in  1  push request for this cycle.
- pop  in  1  pop request for this cycle.
- clr_err  in  1  clears the sticky error flags.
- din  in  WIDTH  value to push.
- dout  out  WIDTH  current top of stack (combinational from state); 0 when empty.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- count  out  $clog2(DEPTH+1)  number of valid entries.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Storage: circular buffer of DEPTH words, a top pointer (index of the top entry) and a count register. Memory contents are not reset.
- Reset (synchronous; sampled at the rising edge and overrides all other inputs in that cycle):
  - count=0, top pointer = DEPTH-1, overflow=0, underflow=0.
  - Resulting outputs: dout=0, empty=1, full=0.
  - Reset asserted mid-sequence discards all entries.
- Stored value V = din + INC_ON_PUSH, truncated to WIDTH bits. So 1023+1 stores 0 when WIDTH=10.
- Timing:
  - All outputs are registered-state functions. An operation at edge N is visible on dout/flags right after edge N; there is no extra latency.
  - dout always shows mem[top] while count>0, so RET can use it in the same cycle pop is asserted.
- Per-cycle operation, evaluated when reset=0:
  - Idle (push=0, pop=0): no state change.
  - Push only, not full: top = top+1 (mod DEPTH); mem[new top] = V; count+1.
  - Push only, full, OVF_MODE=0: stack unchanged; overflow=1.
  - Push only, full, OVF_MODE=1: top = top+1 (mod DEPTH), which overwrites the oldest entry; mem[new top] = V; count stays DEPTH; overflow=1.
  - Pop only, not empty: top = top-1 (mod DEPTH); count-1.
  - Pop only, empty: no change; underflow=1.
  - Push+pop, count>0 ("replace"): mem[top] = V; top and count unchanged; no error flags, even when full.
  - Push+pop, empty: behaves as push only (count becomes 1); underflow=1.
- Pointer wrap: top wraps DEPTH-1 → 0 on increment and 0 → DEPTH-1 on decrement. The logic must be correct for non-power-of-two DEPTH.
- Error flags:
  - Both flags are sticky until clr_err or reset.
  - If clr_err and a new error event occur in the same cycle, the flag ends up 1 (set wins).
  - clr_err has no effect on stack contents.
- Invariant: 0 ≤ count ≤ DEPTH. full and empty are never both 1.

Test Plan:
- Reset, then push din=5,9,20 (INC_ON_PUSH=1) → dout = 6, 10, 21 after each edge; count=3. Three pops → dout = 10, 6, then 0 with empty=1.
- DEPTH=4, OVF_MODE=0: push 0,1,2,3 then push 7 → full=1, overflow=1, count=4, dout=4 (3+1). Pops return 4,3,2,1.
- DEPTH=4, OVF_MODE=1: push 0..4 → count=4, overflow=1. Pops return 5,4,3,2, then empty=1; the entry for 0 is lost.
- Empty, pop → underflow=1, count=0. Next cycle clr_err=1 and pop=1 together → underflow stays 1. Then clr_err alone → underflow=0.
- count=2 (tops 11 then 31 for din 10,30): push+pop with din=50 → dout=51, count=2. Then pop → dout=11. Push+pop while empty with din=7 → count=1, dout=8, underflow=1.
- WIDTH=10: push din=1023 → dout=0, empty=0, count=1. Assert reset mid-sequence with push=1 → count=0, empty=1, dout=0, both flags 0.

Source files
------------

// File: rtl/return_stack.sv
// Parametrised LIFO return-address stack with full/empty/count status,
// sticky overflow/underflow flags, push+pop replace and selectable full policy.
module return_stack #(
    parameter int WIDTH       = 10,
    parameter int DEPTH       = 16,
    parameter int INC_ON_PUSH = 1,
    parameter int OVF_MODE    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    top, top_nxt, top_inc, top_dec, wr_idx;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] inc_val, wr_val;
    logic             is_full, is_empty, wr_en, set_ovf, set_unf;
    logic             ovf_q, unf_q;

    assign inc_val  = (INC_ON_PUSH != 0) ? WIDTH'(1) : '0;
    assign wr_val   = din + inc_val;
    assign is_full  = (cnt == CW'(DEPTH));
    assign is_empty = (cnt == '0);

    // Explicit wrap compares keep the pointer valid for non-power-of-two depths.
    assign top_inc = (top == PW'(DEPTH - 1)) ? '0 : top + PW'(1);
    assign top_dec = (top == '0) ? PW'(DEPTH - 1) : top - PW'(1);

    always_comb begin
        top_nxt = top;
        cnt_nxt = cnt;
        wr_en   = 1'b0;
        wr_idx  = top;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        case ({push, pop})
            2'b11: begin
                wr_en = 1'b1;
                if (is_empty) begin
                    wr_idx  = top_inc;
                    top_nxt = top_inc;
                    cnt_nxt = CW'(1);
                    set_unf = 1'b1;
                end
            end
            2'b10: begin
                if (!is_full) begin
                    wr_en   = 1'b1;
                    wr_idx  = top_inc;
                    top_nxt = top_inc;
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    set_ovf = 1'b1;
                    if (OVF_MODE != 0) begin
                        // Advancing top lands on the oldest slot, overwriting it.
                        wr_en   = 1'b1;
                        wr_idx  = top_inc;
                        top_nxt = top_inc;
                    end
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    top_nxt = top_dec;
                    cnt_nxt = cnt - CW'(1);
                end else begin
                    set_unf = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            top   <= PW'(DEPTH - 1);
            cnt   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            top   <= top_nxt;
            cnt   <= cnt_nxt;
            ovf_q <= set_ovf | (ovf_q & ~clr_err);
            unf_q <= set_unf | (unf_q & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[wr_idx] <= wr_val;
        end
    end

    assign dout      = is_empty ? '0 : mem[top];
    assign empty     = is_empty;
    assign full      = is_full;
    assign count     = cnt;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
